// File: rtl/wm_phase_actuator.sv
// Washing-machine phase actuator: takes one-hot phase commands from the
// controller, sequences fill valve / drum motor / drain valve with cycle
// timers, tracks whether the drum holds water and reports completion/faults.
module wm_phase_actuator #(
  parameter int SOAK_CYCLES  = 16,
  parameter int WASH_CYCLES  = 32,
  parameter int RINSE_CYCLES = 24,
  parameter int SPIN_CYCLES  = 20,
  parameter int FILL_CYCLES  = 8,
  parameter int DRAIN_CYCLES = 6,
  parameter int CNT_W        = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic soak_Operation,
  input  logic wash_Operation,
  input  logic rinse_Operation,
  input  logic spin_Operation,
  input  logic water_Intake,
  input  logic lid,
  output logic fill_Valve,
  output logic drain_Valve,
  output logic motor_Enable,
  output logic motor_Fast,
  output logic water_Full,
  output logic busy,
  output logic phase_Done,
  output logic fault
);

  typedef enum logic [2:0] {
    P_IDLE, P_FILL, P_RUN, P_DRAIN, P_DONE, P_FAULT
  } state_t;

  // Command bit order: {soak, wash, rinse, spin}
  localparam logic [3:0] OP_SPIN = 4'b0001;
  localparam logic [3:0] OP_SOAK = 4'b1000;

  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  // Indexed like the command vector: [0]=spin .. [3]=soak
  localparam int RUN_DUR [0:3] = '{SPIN_CYCLES, RINSE_CYCLES, WASH_CYCLES, SOAK_CYCLES};

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [3:0]       op_reg, op_next;
  logic             water_full_reg, water_full_next;
  logic             abort_reg, abort_next;
  logic             phase_done_reg, phase_done_next;
  logic             fault_reg, fault_next;

  logic [3:0] cmd;
  logic       multi;
  logic       mismatch;
  logic       timer_en;
  logic [3:0] run_hit;
  logic       run_last;

  assign cmd      = {soak_Operation, wash_Operation, rinse_Operation, spin_Operation};
  assign multi    = (cmd & (cmd - 4'd1)) != 4'd0;
  assign mismatch = cmd != op_reg;

  // RUN duration depends on which operation was latched
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_run_hit
      assign run_hit[gi] = op_reg[gi] && (timer_reg == CNT_W'(RUN_DUR[gi] - 1));
    end
  endgenerate
  assign run_last = |run_hit;

  // State, timer, latched op and registered status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= P_IDLE;
      timer_reg      <= '0;
      op_reg         <= 4'd0;
      water_full_reg <= 1'b0;
      abort_reg      <= 1'b0;
      phase_done_reg <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      op_reg         <= op_next;
      water_full_reg <= water_full_next;
      abort_reg      <= abort_next;
      phase_done_reg <= phase_done_next;
      fault_reg      <= fault_next;
    end
  end

  // Next-state logic: command decode, abort handling and timer exits
  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    water_full_next = water_full_reg;
    abort_next      = 1'b0;
    timer_en        = 1'b0;
    case (state_reg)
      P_IDLE: begin
        if (multi) begin
          state_next = P_FAULT;
        end else if (cmd != 4'd0) begin
          op_next = cmd;
          if (cmd == OP_SPIN) state_next = water_full_reg ? P_DRAIN : P_RUN;
          else                state_next = water_full_reg ? P_RUN : P_FILL;
        end
      end
      P_FILL: begin
        timer_en = !lid && water_Intake;
        if (multi) begin
          state_next = P_FAULT;
        end else if (mismatch) begin
          // Partially filled drum is treated as full so it gets drained
          water_full_next = 1'b1;
          abort_next      = 1'b1;
          state_next      = P_DRAIN;
        end else if (timer_en && timer_reg == FILL_LAST) begin
          water_full_next = 1'b1;
          state_next      = P_RUN;
        end
      end
      P_RUN: begin
        timer_en = !lid;
        if (multi) begin
          state_next = P_FAULT;
        end else if (mismatch) begin
          if (water_full_reg) begin
            abort_next = 1'b1;
            state_next = P_DRAIN;
          end else begin
            state_next = P_IDLE;
          end
        end else if (timer_en && run_last) begin
          // Soak keeps its water; spin has already drained
          state_next = (op_reg == OP_SPIN || op_reg == OP_SOAK) ? P_DONE : P_DRAIN;
        end
      end
      P_DRAIN: begin
        timer_en = !lid;
        if (multi) begin
          state_next = P_FAULT;
        end else if (timer_en && timer_reg == DRAIN_LAST) begin
          water_full_next = 1'b0;
          if (abort_reg || mismatch) state_next = P_IDLE;
          else if (op_reg == OP_SPIN) state_next = P_RUN;
          else                        state_next = P_DONE;
        end else begin
          // An abort during drain finishes the drain, then idles
          abort_next = abort_reg || mismatch;
        end
      end
      P_DONE: begin
        if (multi)              state_next = P_FAULT;
        else if (cmd != op_reg) state_next = P_IDLE;
      end
      P_FAULT: begin
        if (cmd == 4'd0) state_next = P_IDLE;
      end
      default: state_next = P_IDLE;
    endcase

    if (state_next != state_reg) timer_next = '0;
    else if (timer_en)           timer_next = timer_reg + CNT_W'(1);
    else                         timer_next = timer_reg;

    phase_done_next = (state_next == P_DONE) && (state_reg != P_DONE);
    fault_next      = (state_next == P_FAULT);
  end

  assign fill_Valve   = (state_reg == P_FILL) && !lid && water_Intake;
  assign motor_Enable = (state_reg == P_RUN) && !lid;
  assign motor_Fast   = (state_reg == P_RUN) && !lid && (op_reg == OP_SPIN);
  assign drain_Valve  = (state_reg == P_DRAIN) && !lid;
  assign busy         = state_reg != P_IDLE;
  assign water_Full   = water_full_reg;
  assign phase_Done   = phase_done_reg;
  assign fault        = fault_reg;

endmodule

// File: tb/tb_wm_phase_actuator.sv
// Directed bench for wm_phase_actuator: phase_Done events are scoreboarded
// (expected cycle + water level queued at command issue, popped by a monitor),
// actuator/status levels are checked inline.
module tb_wm_phase_actuator;

  localparam logic [3:0] SOAK  = 4'b1000;
  localparam logic [3:0] WASH  = 4'b0100;
  localparam logic [3:0] RINSE = 4'b0010;
  localparam logic [3:0] SPIN  = 4'b0001;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] cmd_drv = 4'd0;
  logic water_Intake = 1'b1;
  logic lid = 1'b0;
  logic fill_Valve, drain_Valve, motor_Enable, motor_Fast;
  logic water_Full, busy, phase_Done, fault;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct packed {
    int   cyc;
    logic full;
  } exp_t;
  exp_t exp_q[$];

  wm_phase_actuator dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .soak_Operation (cmd_drv[3]),
    .wash_Operation (cmd_drv[2]),
    .rinse_Operation(cmd_drv[1]),
    .spin_Operation (cmd_drv[0]),
    .water_Intake   (water_Intake),
    .lid            (lid),
    .fill_Valve     (fill_Valve),
    .drain_Valve    (drain_Valve),
    .motor_Enable   (motor_Enable),
    .motor_Fast     (motor_Fast),
    .water_Full     (water_Full),
    .busy           (busy),
    .phase_Done     (phase_Done),
    .fault          (fault)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output vector order: {fill, drain, motor, fast, full, busy, done, fault}
  function automatic logic [7:0] outs();
    return {fill_Valve, drain_Valve, motor_Enable, motor_Fast,
            water_Full, busy, phase_Done, fault};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic go(input logic [3:0] c, output int e0);
    cmd_drv = c;
    e0 = cyc + 1;
  endtask

  task automatic expect_done(input int at, input logic full);
    exp_t e;
    e.cyc  = at;
    e.full = full;
    exp_q.push_back(e);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && phase_Done) begin
        $display("done pulse at cycle %0d water_Full=%0b", cyc, water_Full);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_full", 32'(water_Full), 32'(e.full));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    fork
      monitor_loop();
    join_none

    // Reset
    repeat (3) step();
    chk("reset_outs", 32'(outs()), 32'h0);
    reset_n = 1'b1;
    step();
    chk("idle_outs", 32'(outs()), 32'h0);

    // Wash from empty: FILL 8, RUN 32, DRAIN 6
    go(WASH, e0);
    expect_done(e0 + 46, 1'b0);
    step_to(e0);
    chk("wash_fill", 32'(outs()), 32'b1000_0100);
    step_to(e0 + 10);
    chk("wash_run", 32'(outs()), 32'b0010_1100);
    step_to(e0 + 42);
    chk("wash_drain", 32'(outs()), 32'b0100_1100);
    step_to(e0 + 47);
    chk("wash_hold_done", 32'(outs()), 32'b0000_0100);
    cmd_drv = 4'd0;
    step();
    chk("wash_idle", 32'(outs()), 32'h0);
    $display("wash transaction complete at cycle %0d", cyc);

    // Soak from empty keeps water, then wash skips FILL
    go(SOAK, e0);
    expect_done(e0 + 24, 1'b1);
    step_to(e0 + 26);
    cmd_drv = 4'd0;
    step();
    chk("soak_idle_full", 32'(outs()), 32'b0000_1000);
    go(WASH, e1);
    expect_done(e1 + 38, 1'b0);
    step_to(e1);
    chk("wash_skip_fill", 32'(outs()), 32'b0010_1100);
    step_to(e1 + 39);
    cmd_drv = 4'd0;
    step();
    $display("soak+wash transaction complete at cycle %0d", cyc);

    // Fill again with soak, then spin: DRAIN 6 then fast RUN 20, lid 5 cycles
    go(SOAK, e0);
    expect_done(e0 + 24, 1'b1);
    step_to(e0 + 25);
    cmd_drv = 4'd0;
    step();
    go(SPIN, e0);
    expect_done(e0 + 31, 1'b0);
    step_to(e0 + 2);
    chk("spin_predrain", 32'(outs()), 32'b0100_1100);
    step_to(e0 + 8);
    chk("spin_fast", 32'(outs()), 32'b0011_0100);
    step_to(e0 + 10);
    lid = 1'b1;
    #1;
    chk("spin_lid_motor_off", 32'(outs()), 32'b0000_0100);
    step_to(e0 + 15);
    lid = 1'b0;
    step_to(e0 + 32);
    cmd_drv = 4'd0;
    step();
    $display("spin transaction complete at cycle %0d", cyc);

    // Wash with water_Intake low for 3 cycles during FILL
    go(WASH, e0);
    expect_done(e0 + 49, 1'b0);
    step_to(e0 + 2);
    water_Intake = 1'b0;
    #1;
    chk("intake_low_valve", 32'(fill_Valve), 32'd0);
    step_to(e0 + 5);
    water_Intake = 1'b1;
    step_to(e0 + 50);
    cmd_drv = 4'd0;
    step();
    $display("intake-stall wash complete at cycle %0d", cyc);

    // Wash dropped mid-RUN: abort drain, no phase_Done
    go(WASH, e0);
    step_to(e0 + 17);
    chk("abort_pre_run", 32'(outs()), 32'b0010_1100);
    cmd_drv = 4'd0;
    step();
    chk("abort_drain", 32'(outs()), 32'b0100_1100);
    step_to(e0 + 23);
    chk("abort_still_drain", 32'(busy), 32'd1);
    step_to(e0 + 24);
    chk("abort_idle", 32'(outs()), 32'h0);
    repeat (3) step();
    $display("aborted wash complete at cycle %0d", cyc);

    // Two commands at once in RUN: fault, then release
    go(WASH, e0);
    step_to(e0 + 10);
    cmd_drv = WASH | SPIN;
    step();
    chk("fault_enter", 32'(outs()), 32'b0000_1101);
    step();
    chk("fault_hold", 32'(fault), 32'd1);
    cmd_drv = 4'd0;
    step();
    chk("fault_exit", 32'(outs()), 32'b0000_1000);
    $display("fault transaction complete at cycle %0d", cyc);

    // Empty the drum with a spin, then reset mid-fill
    go(SPIN, e0);
    expect_done(e0 + 26, 1'b0);
    step_to(e0 + 27);
    cmd_drv = 4'd0;
    step();
    go(WASH, e0);
    step_to(e0 + 3);
    chk("midfill_valve", 32'(outs()), 32'b1000_0100);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'h0);
    cmd_drv = 4'd0;
    step();
    reset_n = 1'b1;
    step();
    chk("post_reset_idle", 32'(outs()), 32'h0);
    $display("reset transaction complete at cycle %0d", cyc);

    repeat (2) step();
    chk("all_dones_seen", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
